plab1_imul_var_lat_param: RTL and testbench
===========================================

// Module: plab1_imul_var_lat_param
//
// PURPOSE
//  Parametrised variable-latency integer multiplier; next generation of the
//  zero-skipping iterative multiplier. Supports N-bit operands, low or high
//  result word, and signed, unsigned and signed-by-unsigned modes.
//  Skips up to P_MAX_SKIP zero bits of B per cycle.
//  Sits behind a val/rdy request port in the integer multiply/divide unit.
//
// PARAMETERS
//  P_NBITS     32  operand and result width; >=8, even
//  P_MAX_SKIP   8  max B bits consumed per CALC cycle; power of 2, <=P_NBITS
//
// PORTS
//  clk      in   1                clock
//  reset    in   1                synchronous, active-high reset
//  domain   in   1                security domain; labels all ctrl/data ports
//  in_val   in   1                request valid
//  in_rdy   out  1                request ready
//  in_func  in   2                00 MUL (lo), 01 MULH (s*s hi),
//                                 10 MULHU (u*u hi), 11 MULHSU (s*u hi)
//  in_a     in   P_NBITS          operand A
//  in_b     in   P_NBITS          operand B
//  out_val  out  1                response valid
//  out_rdy  in   1                response ready
//  out_msg  out  P_NBITS          product word selected by func
//
// BEHAVIOUR
//  - Clock and reset: clk rising edge. reset is synchronous and active-high.
//  - Reset: state=IDLE, in_rdy=1, out_val=0, result reg=0, so out_msg=0.
//  - Reset mid-operation: the in-flight op is dropped. IDLE on the next cycle.
//  - FSM IDLE -> CALC on in_go (in_val & in_rdy).
//  - FSM CALC -> DONE when the next B value is 0.
//  - FSM DONE -> IDLE on out_go (out_val & out_rdy).
//  - in_rdy=1 only in IDLE; out_val=1 only in DONE. No accept in a DONE cycle.
//  - Accept: latch func and the sign-fix flag neg.
//    neg = sa^sb (MULH), sa (MULHSU), 0 otherwise.
//  - Accept: A reg (2N bits) = |A| zero-extended; B reg (N bits) = |B|.
//    Abs is applied only to signed operands. |0x80..0| = 0x80..0 unsigned.
//  - Accept: result reg (2N bits) = 0.
//  - CALC step: k = trailing zeros of B[P_MAX_SKIP-1:0] (k=P_MAX_SKIP if all 0).
//  - CALC, k<P_MAX_SKIP: result += A<<k; A <<= k+1; B >>= k+1.
//  - CALC, k=P_MAX_SKIP: A <<= P_MAX_SKIP; B >>= P_MAX_SKIP.
//  - Widths: all arithmetic is mod 2^(2N); overflow bits are discarded.
//  - Final CALC cycle writes neg ? -result : result. Sign fix adds no cycle.
//  - out_msg = result[N-1:0] for MUL, result[2N-1:N] otherwise.
//    Held stable through DONE.
//  - Latency in_go -> out_val = 1 + CALC cycles, with min 1 CALC cycle (B=0).
//    Max is P_NBITS CALC cycles (all ones).
//  - Backpressure: DONE holds indefinitely while out_rdy=0.
//  - Assertions (out of reset): in_val, out_rdy, in_rdy, out_val not X.
//
// STRUCTURE
//  - plab1-imul-msgs.v gains `PLAB1_IMUL_FUNC_{MUL,MULH,MULHU,MULHSU} constants.
//  - State encodings are localparams in the ctrl module.
//  - Dpath and ctrl are separate modules, as in the existing multiplier split.
//  - Dpath -> ctrl: b_next_zero, k-valid.
//  - Ctrl -> dpath: mux selects and enables.
//  - Sub-module plab1_imul_CountTrailingZeros#(P_MAX_SKIP) is a parametrised
//    generalisation of the existing CountZeros block.
//  - Reuse vc_Mux2, vc_Reg, vc_EnReg, vc_SimpleAdder and the vc shifters.
//
// TESTING
//  1. MUL a=3 b=5 -> out 15; 2 CALC cycles; out_val 3 cycles after in_go.
//  2. MUL a=0xdeadbeef b=0 -> out 0 after 1 CALC cycle.
//  3. MULHU a=b=0xffffffff -> 0xfffffffe; 32 CALC cycles (worst case).
//  4. Signed modes:
//     MULH 0x80000000*0xffffffff -> 0x00000000;
//     MULH 0xffffffff*2 -> 0xffffffff;
//     MULHSU 0xffffffff*0xffffffff -> 0xffffffff.
//  5. Backpressure: hold out_rdy=0 for 5 DONE cycles -> out_msg stable,
//     in_rdy=0, completes on out_rdy=1.
//  6. Reset asserted mid-CALC -> next cycle in_rdy=1, out_val=0, out_msg=0.
//     The next request MUL 7*9 returns 63.
//  7. Random: 1000 ops, all funcs, P_MAX_SKIP in {1,4,8} -> matches the golden
//     64-bit product.

Source files
------------

// File: rtl/plab1_imul_var_lat_param_pkg.sv
// rtl/plab1_imul_var_lat_param_pkg.sv - shared function codes and operand-sign helpers
//
// Purpose: multiply function encodings plus helpers that decide which
// operands are treated as signed for a given function.
package plab1_imul_var_lat_param_pkg;

  localparam logic [1:0] PLAB1_IMUL_FUNC_MUL    = 2'b00;
  localparam logic [1:0] PLAB1_IMUL_FUNC_MULH   = 2'b01;
  localparam logic [1:0] PLAB1_IMUL_FUNC_MULHU  = 2'b10;
  localparam logic [1:0] PLAB1_IMUL_FUNC_MULHSU = 2'b11;

  // A is signed for MULH and MULHSU.
  function automatic logic func_a_signed(input logic [1:0] func);
    return (func == PLAB1_IMUL_FUNC_MULH) || (func == PLAB1_IMUL_FUNC_MULHSU);
  endfunction

  // B is signed only for MULH.
  function automatic logic func_b_signed(input logic [1:0] func);
    return func == PLAB1_IMUL_FUNC_MULH;
  endfunction

endpackage

// File: rtl/plab1_imul_var_lat_param_if.sv
// rtl/plab1_imul_var_lat_param_if.sv - request/response val/rdy bundle of the multiplier
//
// Ports: domain (security label), in_val/in_rdy/in_func/in_a/in_b request,
// out_val/out_rdy/out_msg response. master = requester, slave = multiplier.
interface plab1_imul_var_lat_param_if #(
  parameter int P_NBITS = 32
);
  logic               domain;
  logic               in_val;
  logic               in_rdy;
  logic [1:0]         in_func;
  logic [P_NBITS-1:0] in_a;
  logic [P_NBITS-1:0] in_b;
  logic               out_val;
  logic               out_rdy;
  logic [P_NBITS-1:0] out_msg;

  modport master (
    output domain, in_val, in_func, in_a, in_b, out_rdy,
    input  in_rdy, out_val, out_msg
  );

  modport slave (
    input  domain, in_val, in_func, in_a, in_b, out_rdy,
    output in_rdy, out_val, out_msg
  );
endinterface

// File: rtl/plab1_imul_var_lat_param_ctz.sv
// rtl/plab1_imul_var_lat_param_ctz.sv - trailing-zero counter over the low B window
//
// Ports: b_lsbs (in, P_MAX_SKIP bits), k (out, trailing zero count,
// P_MAX_SKIP when all zero), k_valid (out, at least one bit set).
module plab1_imul_var_lat_param_ctz #(
  parameter int P_MAX_SKIP = 8,
  parameter int KW         = $clog2(P_MAX_SKIP + 1)
) (
  input  logic [P_MAX_SKIP-1:0] b_lsbs,
  output logic [KW-1:0]         k,
  output logic                  k_valid
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    k = KW'(P_MAX_SKIP);
    for (int i = P_MAX_SKIP - 1; i >= 0; i--) begin
      if (b_lsbs[i]) k = KW'(i);
    end
  end

  assign k_valid = |b_lsbs;

endmodule

// File: rtl/plab1_imul_var_lat_param.sv
// rtl/plab1_imul_var_lat_param.sv - variable-latency zero-skipping integer multiplier
//
// Ports: clk, reset (sync, active-high), io (slave side of the request/
// response bundle). Accepts in IDLE, iterates in CALC consuming up to
// P_MAX_SKIP bits of B per cycle, presents the selected word in DONE.
module plab1_imul_var_lat_param
  import plab1_imul_var_lat_param_pkg::*;
#(
  parameter int P_NBITS    = 32,
  parameter int P_MAX_SKIP = 8
) (
  input logic                        clk,
  input logic                        reset,
  plab1_imul_var_lat_param_if.slave  io
);

  localparam int KW = $clog2(P_MAX_SKIP + 1);
  localparam int W2 = 2 * P_NBITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [1:0]         func_q, func_d;
  logic               neg_q, neg_d;
  logic [W2-1:0]      a_q, a_d;
  logic [W2-1:0]      res_q, res_d;
  logic [P_NBITS-1:0] b_q, b_d;

  logic               in_go, out_go;
  logic               sa, sb, a_sgn, b_sgn;
  logic [P_NBITS-1:0] a_abs, b_abs;
  logic [KW-1:0]      k, shamt;
  logic               k_valid;
  logic [W2-1:0]      res_sum, a_next;
  logic [P_NBITS-1:0] b_next;
  logic               b_next_zero;
  logic               unused_domain;

  // The domain label does not influence computation.
  assign unused_domain = io.domain;

  assign io.in_rdy  = (state_q == ST_IDLE);
  assign io.out_val = (state_q == ST_DONE);
  assign in_go      = io.in_val & io.in_rdy;
  assign out_go     = io.out_val & io.out_rdy;

  assign io.out_msg = (func_q == PLAB1_IMUL_FUNC_MUL) ? res_q[P_NBITS-1:0]
                                                      : res_q[W2-1:P_NBITS];

  // Magnitudes of signed operands; the most negative value maps to itself,
  // which is its correct unsigned magnitude.
  assign sa    = io.in_a[P_NBITS-1];
  assign sb    = io.in_b[P_NBITS-1];
  assign a_sgn = func_a_signed(io.in_func) & sa;
  assign b_sgn = func_b_signed(io.in_func) & sb;
  assign a_abs = a_sgn ? -io.in_a : io.in_a;
  assign b_abs = b_sgn ? -io.in_b : io.in_b;

  plab1_imul_var_lat_param_ctz #(
    .P_MAX_SKIP (P_MAX_SKIP),
    .KW         (KW)
  ) u_ctz (
    .b_lsbs  (b_q[P_MAX_SKIP-1:0]),
    .k       (k),
    .k_valid (k_valid)
  );

  // A set bit at position k consumes k+1 bits; an empty window consumes
  // P_MAX_SKIP bits, so one shift amount serves both cases.
  assign shamt       = k_valid ? (k + KW'(1)) : KW'(P_MAX_SKIP);
  assign res_sum     = k_valid ? (res_q + (a_q << k)) : res_q;
  assign a_next      = a_q << shamt;
  assign b_next      = b_q >> shamt;
  assign b_next_zero = (b_next == '0);

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_go) begin
          state_d = ST_CALC;
          func_d  = io.in_func;
          neg_d   = a_sgn ^ b_sgn;
          a_d     = {{P_NBITS{1'b0}}, a_abs};
          b_d     = b_abs;
          res_d   = '0;
        end
      end
      ST_CALC: begin
        a_d   = a_next;
        b_d   = b_next;
        res_d = res_sum;
        // Sign fix folded into the last iteration.
        if (b_next_zero) begin
          state_d = ST_DONE;
          res_d   = neg_q ? -res_sum : res_sum;
        end
      end
      ST_DONE: begin
        if (out_go) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      func_q  <= '0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assert property (@(posedge clk) disable iff (reset)
    !$isunknown({io.in_val, io.out_rdy, io.in_rdy, io.out_val}));

endmodule

// File: tb/tb_plab1_imul_var_lat_param.sv
// tb/tb_plab1_imul_var_lat_param.sv - directed and random bench for three skip widths
module tb_plab1_imul_var_lat_param;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         domain = 1'b0;
  logic         in_val = 1'b0;
  logic         out_rdy = 1'b0;
  logic [1:0]   in_func = 2'b00;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  plab1_imul_var_lat_param_if #(.P_NBITS(N)) io8 ();
  plab1_imul_var_lat_param_if #(.P_NBITS(N)) io4 ();
  plab1_imul_var_lat_param_if #(.P_NBITS(N)) io1 ();

  assign io8.domain = domain;  assign io4.domain = domain;  assign io1.domain = domain;
  assign io8.in_val = in_val;  assign io4.in_val = in_val;  assign io1.in_val = in_val;
  assign io8.in_func = in_func; assign io4.in_func = in_func; assign io1.in_func = in_func;
  assign io8.in_a = in_a;      assign io4.in_a = in_a;      assign io1.in_a = in_a;
  assign io8.in_b = in_b;      assign io4.in_b = in_b;      assign io1.in_b = in_b;
  assign io8.out_rdy = out_rdy; assign io4.out_rdy = out_rdy; assign io1.out_rdy = out_rdy;

  plab1_imul_var_lat_param #(.P_NBITS(N), .P_MAX_SKIP(8)) dut8 (.clk(clk), .reset(reset), .io(io8.slave));
  plab1_imul_var_lat_param #(.P_NBITS(N), .P_MAX_SKIP(4)) dut4 (.clk(clk), .reset(reset), .io(io4.slave));
  plab1_imul_var_lat_param #(.P_NBITS(N), .P_MAX_SKIP(1)) dut1 (.clk(clk), .reset(reset), .io(io1.slave));

  logic all_val;
  assign all_val = io8.out_val & io4.out_val & io1.out_val;

  function automatic logic [N-1:0] golden(input logic [1:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] ae, be, p;
    ae = (f == 2'b01 || f == 2'b11) ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
    be = (f == 2'b01) ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
    p  = ae * be;
    return (f == 2'b00) ? p[N-1:0] : p[2*N-1:N];
  endfunction

  // Issue one request and wait until all three instances are in DONE.
  // lat8 = cycles from the accepting edge until out_val of the 8-skip unit.
  task automatic run_op(input logic [1:0] f, input logic [N-1:0] a, input logic [N-1:0] b, output int lat8);
    int cyc;
    lat8 = -1;
    @(negedge clk);
    in_func = f; in_a = a; in_b = b; in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    cyc = 1;
    while (!all_val && cyc < 100) begin
      if (io8.out_val && lat8 < 0) lat8 = cyc;
      @(negedge clk);
      cyc++;
    end
    if (io8.out_val && lat8 < 0) lat8 = cyc;
    total++;
    if (!all_val) begin
      bad++;
      $display("FAIL op_timeout: out_val=%b%b%b after %0d cycles, required 111", io8.out_val, io4.out_val, io1.out_val, cyc);
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({io8.in_rdy, io4.in_rdy, io1.in_rdy} !== 3'b111) begin
      bad++; $display("FAIL reset_in_rdy: got %b%b%b required 111", io8.in_rdy, io4.in_rdy, io1.in_rdy);
    end
    total++;
    if ({io8.out_val, io4.out_val, io1.out_val} !== 3'b000) begin
      bad++; $display("FAIL reset_out_val: got %b%b%b required 000", io8.out_val, io4.out_val, io1.out_val);
    end
    total++;
    if (io8.out_msg !== 32'h0) begin
      bad++; $display("FAIL reset_out_msg: got %h required 00000000", io8.out_msg);
    end
    reset = 1'b0;
  endtask

  task automatic test_mul_basic();
    int lat;
    run_op(2'b00, 32'd3, 32'd5, lat);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL mul_basic_latency: got %0d required 3", lat); end
    total++;
    if (io8.out_msg !== 32'd15) begin bad++; $display("FAIL mul_basic_msg8: got %0d required 15", io8.out_msg); end
    total++;
    if (io1.out_msg !== 32'd15) begin bad++; $display("FAIL mul_basic_msg1: got %0d required 15", io1.out_msg); end
    finish_op();
  endtask

  task automatic test_zero_b();
    int lat;
    run_op(2'b00, 32'hdeadbeef, 32'h0, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL zero_b_latency: got %0d required 2", lat); end
    total++;
    if (io4.out_msg !== 32'h0) begin bad++; $display("FAIL zero_b_msg: got %h required 00000000", io4.out_msg); end
    finish_op();
  endtask

  task automatic test_worst_case();
    int lat;
    run_op(2'b10, 32'hffffffff, 32'hffffffff, lat);
    total++;
    if (lat !== 33) begin bad++; $display("FAIL worst_latency: got %0d required 33", lat); end
    total++;
    if (io8.out_msg !== 32'hfffffffe) begin bad++; $display("FAIL worst_msg: got %h required fffffffe", io8.out_msg); end
    finish_op();
  endtask

  task automatic test_signed();
    logic [1:0]   f_tab [3] = '{2'b01, 2'b01, 2'b11};
    logic [N-1:0] a_tab [3] = '{32'h80000000, 32'hffffffff, 32'hffffffff};
    logic [N-1:0] b_tab [3] = '{32'hffffffff, 32'h00000002, 32'hffffffff};
    logic [N-1:0] e_tab [3] = '{32'h00000000, 32'hffffffff, 32'hffffffff};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(f_tab[i], a_tab[i], b_tab[i], lat);
      total++;
      if (io8.out_msg !== e_tab[i] || io4.out_msg !== e_tab[i] || io1.out_msg !== e_tab[i]) begin
        bad++;
        $display("FAIL signed_%0d: got %h/%h/%h required %h", i, io8.out_msg, io4.out_msg, io1.out_msg, e_tab[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(2'b00, 32'h00001234, 32'h00000010, lat);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (io8.out_msg !== 32'h00012340 || io8.out_val !== 1'b1 || io8.in_rdy !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold_%0d: msg=%h val=%b rdy=%b required msg=00012340 val=1 rdy=0", i, io8.out_msg, io8.out_val, io8.in_rdy);
      end
      @(negedge clk);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    total++;
    if (io8.in_rdy !== 1'b1 || io8.out_val !== 1'b0) begin
      bad++; $display("FAIL backpressure_release: rdy=%b val=%b required rdy=1 val=0", io8.in_rdy, io8.out_val);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    @(negedge clk);
    in_func = 2'b10; in_a = 32'hffffffff; in_b = 32'hffffffff; in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({io8.in_rdy, io4.in_rdy, io1.in_rdy} !== 3'b111 || {io8.out_val, io4.out_val, io1.out_val} !== 3'b000) begin
      bad++; $display("FAIL reset_mid_state: rdy=%b%b%b val=%b%b%b required 111/000", io8.in_rdy, io4.in_rdy, io1.in_rdy, io8.out_val, io4.out_val, io1.out_val);
    end
    total++;
    if (io8.out_msg !== 32'h0 || io1.out_msg !== 32'h0) begin
      bad++; $display("FAIL reset_mid_msg: got %h/%h required 00000000", io8.out_msg, io1.out_msg);
    end
    run_op(2'b00, 32'd7, 32'd9, lat);
    total++;
    if (io8.out_msg !== 32'd63 || io4.out_msg !== 32'd63 || io1.out_msg !== 32'd63) begin
      bad++; $display("FAIL reset_mid_next_op: got %0d/%0d/%0d required 63", io8.out_msg, io4.out_msg, io1.out_msg);
    end
    finish_op();
  endtask

  task automatic test_random();
    logic [N-1:0] edge_tab [4] = '{32'h0, 32'h1, 32'h80000000, 32'hffffffff};
    logic [1:0]   f;
    logic [N-1:0] a, b, exp_msg;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      f = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom & $urandom & $urandom;
        2: b = 32'($urandom_range(0, 255));
        default: begin
          a = edge_tab[$urandom_range(0, 3)];
          b = edge_tab[$urandom_range(0, 3)];
        end
      endcase
      exp_msg = golden(f, a, b);
      run_op(f, a, b, lat);
      total++;
      if (io8.out_msg !== exp_msg || io4.out_msg !== exp_msg || io1.out_msg !== exp_msg) begin
        bad++;
        $display("FAIL random_%0d f=%0d a=%h b=%h: got %h/%h/%h required %h", i, f, a, b, io8.out_msg, io4.out_msg, io1.out_msg, exp_msg);
      end
      finish_op();
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_zero_b();
    test_worst_case();
    test_signed();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
